// File: rtl/frame_window_reader.sv
// frame_window_reader: raster-scans a frame in BRAM and presents each pixel's 3x3 neighbourhood
// (zero-padded at the frame edges) over a valid/ready handshake.
module frame_window_reader #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int PIXEL_WIDTH = 24,
    parameter int ADDR_WIDTH  = $clog2(WIDTH*HEIGHT)
) (
    input  logic                       clk_r,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [ADDR_WIDTH-1:0]      bram_addr,
    input  logic [PIXEL_WIDTH-1:0]     bram_dout,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [9*PIXEL_WIDTH-1:0]   win_data,
    output logic [$clog2(WIDTH)-1:0]   win_x,
    output logic [$clog2(HEIGHT)-1:0]  win_y,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

    // Returns {out_of_bounds, address}; out-of-bounds taps read the centre so the address never wraps.
    function automatic logic [ADDR_WIDTH:0] tap_addr(input logic [XW-1:0] cx, input logic [YW-1:0] cy,
                                                      input logic [ADDR_WIDTH-1:0] cc, input logic [3:0] t);
        logic up, dn, lf, rt, oob;
        logic [ADDR_WIDTH-1:0] a;
        up  = t < 4'd3;
        dn  = t > 4'd5;
        lf  = t == 4'd0 || t == 4'd3 || t == 4'd6;
        rt  = t == 4'd2 || t == 4'd5 || t == 4'd8;
        oob = (up && cy == '0) || (dn && cy == YW'(HEIGHT-1)) || (lf && cx == '0) || (rt && cx == XW'(WIDTH-1));
        a   = cc + (dn ? ADDR_WIDTH'(WIDTH) : '0) - (up ? ADDR_WIDTH'(WIDTH) : '0) + ADDR_WIDTH'(rt) - ADDR_WIDTH'(lf);
        return {oob, oob ? cc : a};
    endfunction

    state_t                  state;
    logic [XW-1:0]           x, nx;
    logic [YW-1:0]           y, ny;
    logic [ADDR_WIDTH-1:0]   ctr;
    logic [3:0]              cnt;
    logic                    oob1, oob2;
    logic [PIXEL_WIDTH-1:0]  taps [9];
    logic                    last_col, last_px;
    logic [ADDR_WIDTH:0]     cur_tap, next_tap;

    assign last_col = x == XW'(WIDTH-1);
    assign last_px  = last_col && y == YW'(HEIGHT-1);
    assign nx       = last_col ? '0 : x + 1'b1;
    assign ny       = last_col ? y + 1'b1 : y;
    assign cur_tap  = tap_addr(x, y, ctr, cnt);
    assign next_tap = tap_addr(nx, ny, ctr + 1'b1, 4'd0);

    for (genvar k = 0; k < 9; k++) begin : g_win
        assign win_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = taps[k];
    end

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            ctr        <= '0;
            cnt        <= '0;
            oob1       <= 1'b0;
            oob2       <= 1'b0;
            bram_addr  <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) taps[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= FETCH;
                    busy      <= 1'b1;
                    x         <= '0;
                    y         <= '0;
                    ctr       <= '0;
                    bram_addr <= '0;
                    oob1      <= 1'b1;
                    cnt       <= 4'd1;
                end
                FETCH, DRAIN: begin
                    // cnt counts edges since tap 0 was driven; data for tap k lands two edges later
                    cnt  <= cnt + 1'b1;
                    oob2 <= oob1;
                    if (cnt >= 4'd2) taps[cnt - 4'd2] <= oob2 ? '0 : bram_dout;
                    if (state == FETCH) begin
                        {oob1, bram_addr} <= cur_tap;
                        if (cnt == 4'd8) state <= DRAIN;
                    end else if (cnt == 4'd10) begin
                        win_valid <= 1'b1;
                        win_x     <= x;
                        win_y     <= y;
                        state     <= PRESENT;
                    end
                end
                PRESENT: if (win_ready) begin
                    win_valid <= 1'b0;
                    if (last_px) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        x                 <= nx;
                        y                 <= ny;
                        ctr               <= ctr + 1'b1;
                        {oob1, bram_addr} <= next_tap;
                        cnt               <= 4'd1;
                        state             <= FETCH;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
